// File: rtl/button_debounce.sv
// -----------------------------------------------------------------------------
// button_debounce
//
// Conditions the four raw push-button pins before the sequence detector sees
// them. Each pin is first brought into the clk domain by a two-flop
// synchroniser. It is then filtered by a per-button stable-time counter. A
// button's debounced level only changes after the synchronised input has
// disagreed with it for DEBOUNCE_CYCLES consecutive cycles. Any single cycle
// of agreement restarts the count, so shorter bounces never get through.
//
// Parameters:
//   DEBOUNCE_CYCLES  cycles of sustained disagreement needed to flip a level
//                    (legal range 2 .. 2^24-1)
//   CNT_W            counter width, 2^CNT_W must exceed DEBOUNCE_CYCLES
//
// Ports:
//   clk        in   system clock, rising edge
//   clr_n      in   asynchronous active-low reset
//   btn_raw    in   [3:0] raw button pins, active high, asynchronous, bouncing
//   btn_level  out  [3:0] debounced level per button
//   btn_pulse  out  [3:0] one-cycle pulse on each debounced 0->1 transition
//   any_pulse  out  OR of btn_pulse, aligned with btn_pulse
// -----------------------------------------------------------------------------
module button_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 1250000,
    parameter int unsigned CNT_W           = 24
) (
    input  logic       clk,
    input  logic       clr_n,
    input  logic [3:0] btn_raw,
    output logic [3:0] btn_level,
    output logic [3:0] btn_pulse,
    output logic       any_pulse
);

    // Terminal count: reached on the DEBOUNCE_CYCLES-th consecutive cycle of
    // disagreement, which is the cycle in which the level is allowed to flip.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [3:0]       sync0;
    logic [3:0]       sync1;
    logic [CNT_W-1:0] cnt [4];

    logic [3:0] differ;   // synchronised input disagrees with debounced level
    logic [3:0] expire;   // disagreement has lasted long enough: flip level
    logic [3:0] rise;     // the flip about to happen is a 0->1 (a press)

    always_comb begin
        differ = '0;
        expire = '0;
        rise   = '0;
        for (int i = 0; i < 4; i++) begin
            differ[i] = sync1[i] != btn_level[i];
            expire[i] = differ[i] && (cnt[i] == CNT_LAST);
            rise[i]   = expire[i] && sync1[i];
        end
    end

    // Two-flop synchroniser; only sync1 is used downstream.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            sync0 <= '0;
            sync1 <= '0;
        end else begin
            sync0 <= btn_raw;
            sync1 <= sync0;
        end
    end

    // Per-button stable-time counters and debounced levels. The counter can
    // never pass CNT_LAST because reaching it while still disagreeing flips
    // the level, and the counter is cleared at the same time.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            for (int i = 0; i < 4; i++) begin
                cnt[i] <= '0;
            end
            btn_level <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (!differ[i]) begin
                    cnt[i] <= '0;
                end else if (expire[i]) begin
                    btn_level[i] <= sync1[i];
                    cnt[i]       <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    // Press pulses are registered alongside the level update, so the pulse
    // and the rising level appear in the same cycle. Releases give no pulse.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            btn_pulse <= '0;
            any_pulse <= 1'b0;
        end else begin
            btn_pulse <= rise;
            any_pulse <= |rise;
        end
    end

endmodule

// File: doc/button_debounce.md
# button_debounce

Front-end conditioning stage for the Arty Z7-10 push-buttons; it sits directly upstream of the button sequence detector. It synchronises the four raw, bouncing button inputs (BTN3..BTN0) to the system clock and filters each one with a stable-time counter. For each button it produces a clean debounced level and a single-cycle press pulse, so the detector sees exactly one event per physical press.

## Interface
- DEBOUNCE_CYCLES, default 1250000: consecutive clock cycles (10 ms at 125 MHz) a synchronised input must differ from the debounced state before the state changes; legal range 2 to 2^24-1.
- CNT_W, default 24: counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
- clk  in  1  125 MHz system clock; all logic is on its rising edge.
- clr_n  in  1  asynchronous, active-low reset.
- btn_raw  in  4  raw button pins, bit i = BTNi, active high, asynchronous to clk, bouncing.
- btn_level  out  4  debounced level per button.
- btn_pulse  out  4  one-cycle pulse on the debounced 0->1 transition of each button.
- any_pulse  out  1  OR of btn_pulse, registered in the same cycle as btn_pulse.

## Operation
- Reset (clr_n low, asynchronous) forces the following to 0: both synchroniser stages, all counters, btn_level, btn_pulse and any_pulse. Outputs stay 0 while clr_n is low. Release is sampled on the next clk edge.
- Synchroniser: each bit passes through two flops, sync0 then sync1. Only sync1 is used downstream.
- The four channels are independent and identical. Per bit i, on every edge:
  - If sync1[i] == btn_level[i]: cnt[i] <= 0.
  - Else if cnt[i] == DEBOUNCE_CYCLES-1: btn_level[i] <= sync1[i] and cnt[i] <= 0.
  - Else: cnt[i] <= cnt[i]+1.
- Any single-cycle agreement between sync1 and btn_level restarts the count. Bounces shorter than DEBOUNCE_CYCLES are therefore fully rejected.
- btn_pulse[i] is registered. It is 1 for exactly the one cycle in which btn_level[i] goes 0->1, and is never asserted on a 1->0 transition.
- Simultaneous presses: each bit pulses independently, so several btn_pulse bits may be high in the same cycle. Resolving chords is the consumer's job.
- Counter arithmetic is unsigned. A counter never exceeds DEBOUNCE_CYCLES-1, so wrap-around is impossible.
- A reset in mid-count discards the count. A button held down through reset release produces a fresh press pulse once DEBOUNCE_CYCLES have elapsed, because btn_level restarts at 0.

## Timing
- Press latency: let edge k be the first edge that samples btn_raw[i]=1, with raw stable from then on.
  - sync1 is 1 after edge k+1.
  - btn_level[i] and btn_pulse[i] go high after edge k+1+DEBOUNCE_CYCLES.
  - Total: DEBOUNCE_CYCLES+2 edges.
- Release latency is identical: btn_level falls DEBOUNCE_CYCLES+2 edges after raw falls. No pulse is generated on release.
- btn_pulse width is exactly 1 cycle. any_pulse is cycle-aligned with btn_pulse.
- Minimum distinguishable press or gap: DEBOUNCE_CYCLES cycles.
- Throughput: one press event per button per 2*DEBOUNCE_CYCLES cycles, at most.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4.
- Reset: hold clr_n=0 with btn_raw=4'b1111 -> all outputs 0 throughout. Release clr_n with raw still held -> btn_level=4'b1111 and btn_pulse=4'b1111 for one cycle, 6 edges after the first sampling edge.
- Clean press on bit 2: raw held high for 20 cycles -> btn_level[2] rises at edge k+5, btn_pulse[2]=1 for exactly one cycle, any_pulse matches. Release -> btn_level[2] falls 6 edges later with no pulse.
- Bounce rejection on bit 3: raw toggles 1,0,1,0,1,1,0 with each value held 1–3 cycles (never 4 consecutive highs), then stays low -> btn_level[3] and btn_pulse[3] remain 0.
- Bounce then settle on bit 1: three sub-4-cycle glitches followed by a steady high -> exactly one btn_pulse[1], 6 edges after the steady-high start.
- Simultaneous press of bits 2 and 3 on the same edge -> btn_pulse=4'b1100 for one cycle and any_pulse=1.
- Mid-count reset: bit 0 high for 3 cycles, clr_n pulsed low, then bit 0 stays high -> no pulse before the reset. After release, a single pulse appears 6 edges later.
